pipe_stage_skid: RTL and testbench

- Parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
- Flush inserts a bubble by invalidating the entries and forcing the control field to a configurable value.
- Generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB enable registers. Stalls are driven by downstream backpressure instead of a global enable.
- Instantiated between any two processor pipeline stages. Data and control fields are sized per instance.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 45 ++++
 rtl/pipe_stage_skid.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding, occupancy codes and the core's default no-op control
// word for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam logic [7:0] CTRL_NOP  = 8'h00;

  function automatic logic [1:0] occ_of(input state_t s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = OCC_ONE;
      TWO:     occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One held beat: valid bit plus data and control fields. Clear drops the beat
// and forces a no-op control word while leaving the data field untouched.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
  parameter logic [DATA_W-1:0] DATA_RST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= DATA_RST;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_BUBBLE;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional PIPE_STAGE_STALL_CNT_EN adds a saturating backpressure counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP),
  parameter logic [DATA_W-1:0] DATA_RST    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  state_t state_q, state_d;

  logic              accept, drain;
  logic              head_load, head_clr, skid_load, skid_clr;
  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data, head_data_in;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_ctrl_in;

  // in_ready decodes registered state only, so out_ready never reaches it.
  assign in_ready  = (state_q != TWO);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_ctrl  = head_valid ? head_ctrl : CTRL_BUBBLE;
  assign occupancy = occ_of(state_q);

  // A held skid entry always refills the head before any new input.
  assign head_data_in = skid_valid ? skid_data : in_data;
  assign head_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;

  always_comb begin
    state_d   = state_q;
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          head_load = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (drain) begin
          head_clr  = 1'b1;
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          head_load = 1'b1;
          skid_clr  = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
      head_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE),
    .DATA_RST    (DATA_RST)
  ) u_head (
    .clk     (clk),
    .rst     (rst),
    .load_i  (head_load),
    .clr_i   (head_clr),
    .data_i  (head_data_in),
    .ctrl_i  (head_ctrl_in),
    .valid_o (head_valid),
    .data_o  (head_data),
    .ctrl_o  (head_ctrl)
  );

  pipe_slot #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE),
    .DATA_RST    (DATA_RST)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .data_i  (in_data),
    .ctrl_i  (in_ctrl),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed stimulus, a negedge monitor
// that queues accepted beats and checks each drained beat in FIFO order.
module tb_pipe_stage_skid;

  localparam int unsigned       DW    = 16;
  localparam int unsigned       CW    = 8;
  localparam logic [CW-1:0]     BUB   = 8'h5A;
  localparam logic [DW-1:0]     DRST  = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;

  beat_t exp_q[$];
  int    nvec = 0;
  int    nmis = 0;

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .CTRL_BUBBLE (BUB),
    .DATA_RST    (DRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: drained beats are checked before this cycle's accept is queued.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL sb_unexpected: got beat %0h/%0h expected none at %0t",
                 out_data, out_ctrl, $time);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("sb_data", 64'(out_data), 64'(e.d));
        chk("sb_ctrl", 64'(out_ctrl), 64'(e.c));
      end
    end
    if (rst === 1'b1 || flush === 1'b1)
      exp_q.delete();
    else if (in_valid === 1'b1 && in_ready === 1'b1)
      exp_q.push_back('{d: in_data, c: in_ctrl});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_occ"},       64'(occupancy), 64'd0);
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'(BUB));
    chk({tag, "_out_data"},  64'(out_data),  64'(DRST));
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'h0099, 8'h33);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk_reset_vals("reset");
    tick();

    // Streaming at full rate, 1-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(i < 8, 16'(16'h10 + i), 8'(8'h20 + i));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_data",  64'(out_data),  64'(16'h10 + i - 1));
      end
      tick();
    end

    // Backpressure fills the skid, then drains in order.
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 8'h41);
    tick();
    drive(1'b1, 16'h0002, 8'h42);
    tick();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("bp_occ_full",   64'(occupancy), 64'd2);
    chk("bp_in_ready_0", 64'(in_ready),  64'd0);
    chk("bp_head_a",     64'(out_data),  64'h1);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_a",    64'(out_data),  64'h1);
    chk("bp_in_ready_a", 64'(in_ready),  64'd0);
    tick();
    @(negedge clk);
    chk("bp_in_ready_1", 64'(in_ready),  64'd1);
    chk("bp_occ_one",    64'(occupancy), 64'd1);
    chk("bp_head_b",     64'(out_data),  64'h2);
    chk("bp_ctrl_b",     64'(out_ctrl),  64'h42);
    tick();
    @(negedge clk);
    chk("bp_occ_empty",  64'(occupancy), 64'd0);
    chk("bp_valid_0",    64'(out_valid), 64'd0);
    chk("bp_ctrl_bub",   64'(out_ctrl),  64'(BUB));
    tick();

    // Flush while full, with an accept attempt in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 16'h0003, 8'h43);
    tick();
    drive(1'b1, 16'h0004, 8'h44);
    tick();
    drive(1'b1, 16'h00EE, 8'hEE);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("fl_valid",    64'(out_valid), 64'd0);
    chk("fl_occ",      64'(occupancy), 64'd0);
    chk("fl_ctrl",     64'(out_ctrl),  64'(BUB));
    chk("fl_in_ready", 64'(in_ready),  64'd1);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_no_ghost", 64'(out_valid), 64'd0);
      tick();
    end

    // Simultaneous accept and drain in ONE, then reset while full.
    drive(1'b1, 16'h0005, 8'h55);
    tick();
    drive(1'b1, 16'h0006, 8'h56);
    @(negedge clk);
    chk("ad_head_5", 64'(out_data),  64'h5);
    chk("ad_occ_a",  64'(occupancy), 64'd1);
    tick();
    out_ready = 1'b0;
    drive(1'b1, 16'h0007, 8'h57);
    @(negedge clk);
    chk("ad_head_6", 64'(out_data),  64'h6);
    chk("ad_occ_b",  64'(occupancy), 64'd1);
    tick();
    drive(1'b0, '0, '0);
    @(negedge clk);
    chk("ad_occ_full", 64'(occupancy), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
    out_ready = 1'b0;
    drive(1'b1, 16'h0009, 8'h59);
    tick();
    drive(1'b0, '0, '0);
    repeat (70000) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("stall_hold_flush", 64'(stall_cnt), 64'hFFFF);
    chk("stall_flush_valid", 64'(out_valid), 64'd0);
    tick();
`endif

    repeat (2) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
